// File: rtl/accel_pkg.sv
// Shared types and constants for the accelerometer BCD scheduler.
// Build option: MG_SCALE_EN selects a 12-bit operand ({mag, 2'b00}, roughly
// milli-g). Without it the operand is the 10-bit magnitude (raw LSB count).
package accel_pkg;

`ifdef MG_SCALE_EN
   localparam int OPND_W = 12;
`else
   localparam int OPND_W = 10;
`endif

   // One double-dabble iteration per operand bit.
   localparam int N_ITER = OPND_W;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_SHIFT,
      ST_STORE,
      ST_COMMIT
   } state_e;

   typedef enum logic [1:0] {
      AX_X,
      AX_Y,
      AX_Z
   } axis_e;

   typedef logic [3:0]        bcd_digit_t;
   typedef logic [15:0]       bcd_group_t;
   typedef logic [OPND_W-1:0] opnd_t;

   // The 10-bit reading is split across the two register bytes of the raw word.
   function automatic logic [9:0] axis_value(input logic [15:0] d);
      return {d[6:0], d[15:13]};
   endfunction

   function automatic opnd_t axis_operand(input logic [15:0] d);
      logic [9:0] v;
      logic [9:0] m;
      v = axis_value(d);
      // -512 negates to itself, which reads as +512 when taken unsigned.
      m = v[9] ? (~v + 10'd1) : v;
`ifdef MG_SCALE_EN
      return {m, 2'b00};
`else
      return m;
`endif
   endfunction

endpackage

// File: rtl/bcd_shift_unit.sv
// Bit-serial binary-to-BCD converter (shift-and-add-3).
// Ports:
//   clk, reset   clock and asynchronous active-high reset
//   load         load operand, clear digits and iteration counter
//   step         perform one adjust-and-shift iteration
//   operand      binary magnitude to convert
//   digits       {thousands, hundreds, tens, ones}
//   done_count   high while the counter holds the last iteration index
module bcd_shift_unit
   import accel_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       load,
   input  logic       step,
   input  opnd_t      operand,
   output bcd_group_t digits,
   output logic       done_count
);

   bcd_group_t acc_q;
   bcd_group_t acc_adj;
   opnd_t      sr_q;
   logic [3:0] cnt_q;

   always_comb begin
      acc_adj = acc_q;
      for (int i = 0; i < 4; i++) begin
         if (bcd_digit_t'(acc_q[4*i +: 4]) >= 4'd5) begin
            acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc_q <= '0;
         sr_q  <= '0;
         cnt_q <= '0;
      end else if (load) begin
         acc_q <= '0;
         sr_q  <= operand;
         cnt_q <= '0;
      end else if (step) begin
         {acc_q, sr_q} <= {acc_adj, sr_q} << 1;
         cnt_q         <= cnt_q + 4'd1;
      end
   end

   assign digits     = acc_q;
   assign done_count = (cnt_q == 4'(N_ITER - 1));

endmodule

// File: rtl/accel_bcd_scheduler.sv
// Shares one bit-serial BCD converter across the X/Y/Z accelerometer axes and
// commits all three axes at once; buffers one sample arriving while busy.
// Build option: MG_SCALE_EN (12-bit milli-g operand instead of raw counts).
// Ports:
//   clk, reset               clock, asynchronous active-high reset
//   sample_valid             strobe; x/y/z_data valid this cycle
//   x_data, y_data, z_data   raw 16-bit axis words
//   busy                     registered, high while not idle
//   done                     one-cycle pulse when new digits are committed
//   overrun                  one-cycle pulse when the pending sample is lost
//   x/y/z_bcd, x/y/z_neg     committed digits and signs
//
// state     | meaning
// IDLE      | waiting for sample_valid
// LOAD      | load current axis operand into the shift unit
// SHIFT     | one conversion iteration per cycle
// STORE     | park digits and sign in the axis shadow
// COMMIT    | publish shadows, pulse done, start pending sample if any
module accel_bcd_scheduler
   import accel_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        sample_valid,
   input  logic [15:0] x_data,
   input  logic [15:0] y_data,
   input  logic [15:0] z_data,
   output logic        busy,
   output logic        done,
   output logic        overrun,
   output logic [15:0] x_bcd,
   output logic [15:0] y_bcd,
   output logic [15:0] z_bcd,
   output logic        x_neg,
   output logic        y_neg,
   output logic        z_neg
);

   state_e      state_q;
   axis_e       axis_q;
   logic [15:0] wk_q   [3];
   logic [15:0] pend_q [3];
   logic        pending_q;
   bcd_group_t  sh_bcd_q  [3];
   logic [2:0]  sh_neg_q;
   bcd_group_t  out_bcd_q [3];
   logic [2:0]  out_neg_q;
   logic        busy_q;
   logic        done_q;
   logic        overrun_q;

   logic [15:0] cur_word;
   bcd_group_t  digits;
   logic        done_count;

   assign cur_word = wk_q[axis_q];

   bcd_shift_unit u_shift (
      .clk        (clk),
      .reset      (reset),
      .load       (state_q == ST_LOAD),
      .step       (state_q == ST_SHIFT),
      .operand    (axis_operand(cur_word)),
      .digits     (digits),
      .done_count (done_count)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         axis_q    <= AX_X;
         wk_q      <= '{default: '0};
         pend_q    <= '{default: '0};
         pending_q <= 1'b0;
         sh_bcd_q  <= '{default: '0};
         sh_neg_q  <= '0;
         out_bcd_q <= '{default: '0};
         out_neg_q <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         done_q    <= 1'b0;
         overrun_q <= 1'b0;

         // Capture while busy; COMMIT may override pending_q below because it
         // consumes the old buffer in the same cycle.
         if (sample_valid && state_q != ST_IDLE) begin
            pend_q    <= '{x_data, y_data, z_data};
            pending_q <= 1'b1;
            if (pending_q && state_q != ST_COMMIT) begin
               overrun_q <= 1'b1;
            end
         end

         case (state_q)
            ST_IDLE: begin
               if (sample_valid) begin
                  wk_q    <= '{x_data, y_data, z_data};
                  axis_q  <= AX_X;
                  state_q <= ST_LOAD;
                  busy_q  <= 1'b1;
               end
            end
            ST_LOAD: state_q <= ST_SHIFT;
            ST_SHIFT: begin
               if (done_count) begin
                  state_q <= ST_STORE;
               end
            end
            ST_STORE: begin
               sh_bcd_q[axis_q] <= digits;
               sh_neg_q[axis_q] <= cur_word[6];   // value[9]
               if (axis_q == AX_Z) begin
                  state_q <= ST_COMMIT;
               end else begin
                  axis_q  <= axis_e'(axis_q + 2'd1);
                  state_q <= ST_LOAD;
               end
            end
            ST_COMMIT: begin
               out_bcd_q <= sh_bcd_q;
               out_neg_q <= sh_neg_q;
               done_q    <= 1'b1;
               axis_q    <= AX_X;
               if (pending_q) begin
                  wk_q      <= pend_q;
                  pending_q <= sample_valid;
                  state_q   <= ST_LOAD;
               end else if (sample_valid) begin
                  // Nothing queued: start the coincident sample directly so it
                  // is never stranded in the buffer once the FSM goes idle.
                  wk_q      <= '{x_data, y_data, z_data};
                  pending_q <= 1'b0;
                  state_q   <= ST_LOAD;
               end else begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign overrun = overrun_q;
   assign x_bcd   = out_bcd_q[0];
   assign y_bcd   = out_bcd_q[1];
   assign z_bcd   = out_bcd_q[2];
   assign x_neg   = out_neg_q[0];
   assign y_neg   = out_neg_q[1];
   assign z_neg   = out_neg_q[2];

endmodule
